disparity_upsampler: RTL and testbench

DISPARITY_UPSAMPLER -- requirements
Module: disparity_upsampler

---
 rtl/upsampler_pkg.sv | 26 ++
 rtl/upsampler_lerp.sv | 50 +++++
 rtl/disparity_upsampler.sv | 149 ++++++++++++++
 tb/tb_disparity_upsampler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/upsampler_pkg.sv
// -----------------------------------------------------------------------------
// upsampler_pkg
// Shared types and helpers for the disparity upsampler.
//   state_t     : row sequencing states (IDLE, WAIT, EMIT, FLUSH)
//   ratio_log2  : log2 of the (power-of-two) upsampling ratio, used to size
//                 the phase counter and the interpolation product
// -----------------------------------------------------------------------------
package upsampler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // no sample of the current row held
      ST_WAIT  = 2'd1,   // prev held, waiting for the next sample
      ST_EMIT  = 2'd2,   // emitting pixels between prev and cur
      ST_FLUSH = 2'd3    // replicating the last sample to close the row
   } state_t;

   // Smallest r with 2**r >= ratio; exact log2 for power-of-two ratios.
   function automatic int ratio_log2(input int ratio);
      int r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < ratio) r = i + 1;
      end
      return r;
   endfunction

endpackage : upsampler_pkg

// File: rtl/upsampler_lerp.sv
// -----------------------------------------------------------------------------
// upsampler_lerp
// Combinational linear interpolation between two samples:
//   value = prev + floor((cur - prev) * k / up_ratio)
// Ports:
//   prev  [bits-1:0]  start sample (phase 0)
//   cur   [bits-1:0]  end sample (reached at phase up_ratio)
//   k     [log2-1:0]  phase, 0 .. up_ratio-1
//   value [bits-1:0]  interpolated pixel
// -----------------------------------------------------------------------------
module upsampler_lerp
   import upsampler_pkg::*;
#(
   parameter int bits     = 8,
   parameter int up_ratio = 4
) (
   input  logic [bits-1:0]                 prev,
   input  logic [bits-1:0]                 cur,
   input  logic [ratio_log2(up_ratio)-1:0] k,
   output logic [bits-1:0]                 value
);

   localparam int KW = ratio_log2(up_ratio);
   localparam int PW = bits + 1 + KW;

   logic signed [bits:0]  diff;
   logic signed [PW-1:0]  diff_ext;
   logic signed [PW-1:0]  k_ext;
   logic signed [PW-1:0]  prod;
   logic signed [PW-1:0]  step;
   logic signed [PW-1:0]  sum;
   logic                  unused_sum_hi;

   // |diff * k| < 2**(bits+KW), so the product always fits in PW signed bits,
   // and the arithmetic shift floors toward minus infinity as required.
   always_comb begin
      diff     = $signed({1'b0, cur}) - $signed({1'b0, prev});
      diff_ext = {{KW{diff[bits]}}, diff};
      k_ext    = {{(bits + 1){1'b0}}, k};
      prod     = diff_ext * k_ext;
      step     = prod >>> KW;
      sum      = step + $signed({{(KW + 1){1'b0}}, prev});
      value    = sum[bits-1:0];
   end

   // The result lies between prev and cur, so the upper sum bits are always
   // zero; fold them into a dummy so they are consumed.
   assign unused_sum_hi = ^sum[PW-1:bits];

endmodule : upsampler_lerp

// File: rtl/disparity_upsampler.sv
// -----------------------------------------------------------------------------
// disparity_upsampler
// Expands a decimated disparity stream by up_ratio along a row. Each pair of
// consecutive samples produces up_ratio pixels; the last sample of a row is
// replicated up_ratio times, so in_per_row samples yield row_width pixels.
// Build option: define UPSAMPLER_INTERP_EN for linear interpolation between
// samples; otherwise pixels hold the earlier sample (sample-and-hold) with
// identical sequencing and timing.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   sample, sample_valid  decimated input (valid/ready handshake)
//   sample_ready          high in IDLE and WAIT
//   pixel, pixel_valid    full-rate output (valid/ready handshake)
//   pixel_ready           downstream accept
//   pixel_last            marks the final pixel of each row
// All outputs come from state or registers only.
// -----------------------------------------------------------------------------
module disparity_upsampler
   import upsampler_pkg::*;
#(
   parameter int bits      = 8,
   parameter int up_ratio  = 4,
   parameter int row_width = 640
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [bits-1:0] sample,
   input  logic            sample_valid,
   output logic            sample_ready,
   output logic [bits-1:0] pixel,
   output logic            pixel_valid,
   input  logic            pixel_ready,
   output logic            pixel_last
);

   localparam int KW         = ratio_log2(up_ratio);
   localparam int IN_PER_ROW = row_width / up_ratio;
   localparam int CW         = $clog2(IN_PER_ROW + 1);

   generate
      if ((up_ratio < 2) || ((up_ratio & (up_ratio - 1)) != 0)
          || ((row_width % up_ratio) != 0)) begin : g_bad_params
         $error("disparity_upsampler: up_ratio must be a power of 2 >= 2 and divide row_width");
      end
   endgenerate

   state_t          state_q, state_d;
   logic [bits-1:0] prev_q,  prev_d;
   logic [bits-1:0] cur_q,   cur_d;
   logic [KW-1:0]   k_q,     k_d;
   logic [CW-1:0]   count_q, count_d;

   logic            sample_fire;
   logic            pixel_fire;
   logic            k_last;
   logic [bits-1:0] emit_value;

   // NOTE: prev/cur are plain data registers but are still reset, because the
   // pixel output must read as zero straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         prev_q  <= '0;
         cur_q   <= '0;
         k_q     <= '0;
         count_q <= '0;
      end else begin
         // NOTE: non-blocking here so every flop samples the pre-edge values.
         state_q <= state_d;
         prev_q  <= prev_d;
         cur_q   <= cur_d;
         k_q     <= k_d;
         count_q <= count_d;
      end
   end

   assign sample_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
   assign pixel_valid  = (state_q == ST_EMIT) || (state_q == ST_FLUSH);
   assign sample_fire  = sample_valid && sample_ready;
   assign pixel_fire   = pixel_valid && pixel_ready;
   assign k_last       = (k_q == KW'(up_ratio - 1));

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      state_d = state_q;
      prev_d  = prev_q;
      cur_d   = cur_q;
      k_d     = k_q;
      count_d = count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (sample_fire) begin
               prev_d  = sample;
               count_d = CW'(1);
               k_d     = '0;
               state_d = (IN_PER_ROW == 1) ? ST_FLUSH : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (sample_fire) begin
               cur_d   = sample;
               k_d     = '0;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (pixel_fire) begin
               // Phase counter wraps to 0 naturally after up_ratio-1.
               k_d = k_q + KW'(1);
               if (k_last) begin
                  prev_d  = cur_q;
                  count_d = count_q + CW'(1);
                  state_d = (count_q + CW'(1) == CW'(IN_PER_ROW)) ? ST_FLUSH : ST_WAIT;
               end
            end
         end
         ST_FLUSH: begin
            if (pixel_fire) begin
               k_d = k_q + KW'(1);
               if (k_last) begin
                  k_d     = '0;
                  count_d = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef UPSAMPLER_INTERP_EN
   upsampler_lerp #(
      .bits     (bits),
      .up_ratio (up_ratio)
   ) u_lerp (
      .prev  (prev_q),
      .cur   (cur_q),
      .k     (k_q),
      .value (emit_value)
   );
`else
   assign emit_value = prev_q;
`endif

   assign pixel      = (state_q == ST_EMIT) ? emit_value : prev_q;
   assign pixel_last = (state_q == ST_FLUSH) && k_last;

endmodule : disparity_upsampler

// File: tb/tb_disparity_upsampler.sv
// -----------------------------------------------------------------------------
// tb_disparity_upsampler
// Self-checking bench for disparity_upsampler (bits=8, up_ratio=4,
// row_width=16). Row vectors live in a table; expected pixels are queued when
// a row is started and compared as the DUT transfers them.
// -----------------------------------------------------------------------------
module tb_disparity_upsampler;

   localparam int BITS = 8;
   localparam int UR   = 4;
   localparam int RW   = 16;
   localparam int NSMP = RW / UR;
   localparam int NVEC = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic [BITS-1:0] sample;
   logic            sample_valid;
   logic            sample_ready;
   logic [BITS-1:0] pixel;
   logic            pixel_valid;
   logic            pixel_ready;
   logic            pixel_last;

   disparity_upsampler #(
      .bits      (BITS),
      .up_ratio  (UR),
      .row_width (RW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pixel        (pixel),
      .pixel_valid  (pixel_valid),
      .pixel_ready  (pixel_ready),
      .pixel_last   (pixel_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s[NSMP];   // samples of one row
      int e[RW];     // interpolated pixels for that row
   } vec_t;

   typedef struct {
      int pix;
      bit last;
   } exp_t;

   vec_t tbl[NVEC];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Sample-and-hold builds repeat the earlier sample of each pair.
   function automatic int exp_pix(input int idx, input int j);
`ifdef UPSAMPLER_INTERP_EN
      return tbl[idx].e[j];
`else
      return tbl[idx].s[j / UR];
`endif
   endfunction

   task automatic push_row(input int idx);
      for (int j = 0; j < RW; j++) begin
         exp_t x;
         x.pix  = exp_pix(idx, j);
         x.last = (j == RW - 1);
         sb.push_back(x);
      end
   endtask

   // Entered and left at posedge+1.
   task automatic send_sample(input int v, input int gap);
      bit accepted = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      sample       = BITS'(v);
      sample_valid = 1'b1;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (sample_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) check("sample_accept_timeout", int'(sample_ready), 1);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic drain_and_idle();
      for (int n = 0; n < 400; n++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("drain_remaining", sb.size(), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("idle_sample_ready", int'(sample_ready), 1);
      check("idle_pixel_valid", int'(pixel_valid), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_row(input int idx, input int max_gap);
      push_row(idx);
      for (int i = 0; i < NSMP; i++) begin
         send_sample(tbl[idx].s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      end
      drain_and_idle();
   endtask

   // Scoreboard consumer: a pixel transfers at the next posedge whenever
   // valid and ready are both high at the preceding negedge.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && pixel_valid && pixel_ready) begin
            if (sb.size() == 0) begin
               check("extra_pixel", int'(pixel_valid), 0);
            end else begin
               exp_t x;
               x = sb.pop_front();
               check("pixel", int'(pixel), x.pix);
               check("pixel_last", int'(pixel_last), int'(x.last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0].s = '{0, 40, 80, 120};
      tbl[0].e = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110, 120, 120, 120, 120};
      tbl[1].s = '{0, 3, 3, 3};
      tbl[1].e = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      tbl[2].s = '{3, 0, 0, 0};
      tbl[2].e = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[3].s = '{255, 0, 0, 0};
      tbl[3].e = '{255, 191, 127, 63, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[4].s = '{0, 255, 255, 255};
      tbl[4].e = '{0, 63, 127, 191, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
      tbl[5].s = '{5, 5, 5, 5};
      tbl[5].e = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};

      reset        = 1'b1;
      sample       = '0;
      sample_valid = 1'b0;
      pixel_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_pixel_valid", int'(pixel_valid), 0);
      check("reset_sample_ready", int'(sample_ready), 1);
      check("reset_pixel", int'(pixel), 0);
      check("reset_pixel_last", int'(pixel_last), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Gap-free rows straight from the table.
      for (int i = 0; i < NVEC; i++) run_row(i, 0);

      // Random sample_valid gaps must not change values or count.
      run_row(0, 6);
      run_row(3, 6);

      // Backpressure: stall three cycles at phase 2 of the first pair.
      push_row(0);
      pixel_ready = 1'b0;
      send_sample(tbl[0].s[0], 0);
      send_sample(tbl[0].s[1], 0);
      @(negedge clk);
      check("first_valid_latency", int'(pixel_valid), 1);
      check("first_pixel_value", int'(pixel), exp_pix(0, 0));
      @(posedge clk);
      #1;
      pixel_ready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      pixel_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_pixel", int'(pixel), exp_pix(0, 2));
         check("stall_pixel_valid", int'(pixel_valid), 1);
         check("stall_sample_ready", int'(sample_ready), 0);
         check("stall_pixel_last", int'(pixel_last), 0);
      end
      @(posedge clk);
      #1;
      pixel_ready = 1'b1;
      send_sample(tbl[0].s[2], 0);
      send_sample(tbl[0].s[3], 0);
      drain_and_idle();

      // Reset in the middle of EMIT drops the row; the next row starts clean.
      push_row(0);
      send_sample(tbl[0].s[0], 0);
      send_sample(tbl[0].s[1], 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrow_reset_pixel_valid", int'(pixel_valid), 0);
      check("midrow_reset_sample_ready", int'(sample_ready), 1);
      check("midrow_reset_pixel", int'(pixel), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run_row(5, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_disparity_upsampler
